// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage.
// IF_ADEF_CHECK_EN enables fetch-address alignment checking in if_stage.
package if_stage_pkg;

    localparam logic [31:0] PC_RESET      = 32'h1c00_0000;
    localparam logic [31:0] NOP_INST      = 32'h0340_0000;
    localparam logic [5:0]  ECODE_ADE     = 6'h08;
    localparam logic [8:0]  ESUBCODE_ADEF = 9'h000;

    // A fetch address is misaligned when either of its two low bits is set.
    function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_cancel_ctr.sv
// Outstanding-discard counter: counts fetch returns that must be thrown away
// after a flush. Two increment sources, one decrement, saturating at the top.
module if_cancel_ctr
    import if_stage_pkg::*;
#(
    parameter int CANCEL_W = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                inc0,
    input  logic                inc1,
    input  logic                dec,
    output logic [CANCEL_W-1:0] cnt,
    output logic                zero,
    output logic                sat
);

    localparam logic [CANCEL_W+1:0] MAX_WIDE = {2'b00, {CANCEL_W{1'b1}}};

    logic [CANCEL_W+1:0] sum;
    logic [CANCEL_W-1:0] cnt_next;

    // Net change of both increments and the decrement, clamped at the maximum.
    always_comb begin
        sum = {2'b00, cnt} + {{(CANCEL_W+1){1'b0}}, inc0} + {{(CANCEL_W+1){1'b0}}, inc1};
        if (dec && (cnt != '0)) begin
            sum = sum - 1'b1;
        end
        if (sum > MAX_WIDE) begin
            cnt_next = MAX_WIDE[CANCEL_W-1:0];
        end else begin
            cnt_next = sum[CANCEL_W-1:0];
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    assign zero = (cnt == '0);
    assign sat  = (cnt == MAX_WIDE[CANCEL_W-1:0]);

    // Hitting the top means more fetches were in flight than we can track.
    a_no_saturation: assert property (@(posedge clk) disable iff (!resetn) !sat);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: holds one fetch PC, waits for its data return,
// buffers the instruction while ID stalls and drops stale returns after flush.
// IF_ADEF_CHECK_EN: flag misaligned fetch PCs as ADEF instead of fetching.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int CANCEL_W = 2,
    parameter int PC_W     = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            from_valid,
    input  logic [PC_W-1:0] from_pc,
    output logic            to_allowin,
    input  logic            flush,
    input  logic            inst_sram_data_ok,
    input  logic [31:0]     inst_sram_rdata,
    input  logic            id_allowin,
    output logic            to_id_valid,
    output logic [PC_W-1:0] to_id_pc,
    output logic [31:0]     to_id_inst,
    output logic            to_id_excp
);

    logic                valid;
    logic [PC_W-1:0]     pc;
    logic [31:0]         inst_buf;
    logic                inst_buf_valid;
    logic [CANCEL_W-1:0] cancel_cnt;
    logic                cnt_zero;
    logic                cnt_sat;
    logic                excp;
    logic                from_excp;
    logic                data_arrive;
    logic                ready_go;
    logic                handoff;
    logic                accept;
    logic                inc_outstanding;
    logic                inc_issued;
    logic                drop;

`ifdef IF_ADEF_CHECK_EN
    assign from_excp = pc_misaligned(from_pc[1:0]);

    // Exception flag travels with the PC it belongs to.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            excp <= 1'b0;
        end else if (accept) begin
            excp <= from_excp;
        end
    end
`else
    assign from_excp = 1'b0;
    assign excp      = 1'b0;
`endif

    assign data_arrive = inst_sram_data_ok && cnt_zero;
    assign ready_go    = valid && (excp || inst_buf_valid || data_arrive);
    assign handoff     = ready_go && id_allowin;
    assign to_allowin  = ~valid || handoff;
    assign accept      = from_valid && to_allowin && ~flush;

    assign to_id_valid = ready_go && ~flush;
    assign to_id_pc    = pc;
    assign to_id_inst  = excp ? 32'h0 : (inst_buf_valid ? inst_buf : inst_sram_rdata);
    assign to_id_excp  = valid && excp;

    // An excepting entry never issued a request, so it is never outstanding.
    assign inc_outstanding = flush && valid && ~inst_buf_valid && ~data_arrive && ~excp;
    assign inc_issued      = flush && from_valid && to_allowin && ~from_excp;
    assign drop            = inst_sram_data_ok && ~cnt_zero;

    if_cancel_ctr #(.CANCEL_W(CANCEL_W)) u_cancel_ctr (
        .clk    (clk),
        .resetn (resetn),
        .inc0   (inc_outstanding),
        .inc1   (inc_issued),
        .dec    (drop),
        .cnt    (cancel_cnt),
        .zero   (cnt_zero),
        .sat    (cnt_sat)
    );

    // Stage occupancy and the PC of the fetch it holds.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid <= 1'b0;
            pc    <= PC_W'(PC_RESET);
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (accept) begin
                valid <= 1'b1;
            end else if (handoff) begin
                valid <= 1'b0;
            end
            if (accept) begin
                pc <= from_pc;
            end
        end
    end

    // Capture returned data while ID is not ready to take it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_buf       <= 32'h0;
            inst_buf_valid <= 1'b0;
        end else if (flush || accept || handoff) begin
            inst_buf_valid <= 1'b0;
        end else if (data_arrive && valid && ~id_allowin) begin
            inst_buf       <= inst_sram_rdata;
            inst_buf_valid <= 1'b1;
        end
    end

    // A data return with nothing waiting for it and nothing to discard is a bus error.
    a_no_orphan_data: assert property (@(posedge clk) disable iff (!resetn)
        !(inst_sram_data_ok && !valid && cnt_zero));

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

`ifdef IF_ADEF_CHECK_EN
    localparam bit ADEF_ON = 1'b1;
`else
    localparam bit ADEF_ON = 1'b0;
`endif

    typedef struct packed {
        bit          fv;
        logic [31:0] fpc;
        bit          fl;
        bit          dok;
        logic [31:0] rd;
        bit          ida;
    } stim_t;

    logic        clk;
    logic        resetn;
    logic        from_valid;
    logic [31:0] from_pc;
    logic        to_allowin;
    logic        flush;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        id_allowin;
    logic        to_id_valid;
    logic [31:0] to_id_pc;
    logic [31:0] to_id_inst;
    logic        to_id_excp;

    int checks   = 0;
    int failures = 0;

    if_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .from_valid        (from_valid),
        .from_pc           (from_pc),
        .to_allowin        (to_allowin),
        .flush             (flush),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .id_allowin        (id_allowin),
        .to_id_valid       (to_id_valid),
        .to_id_pc          (to_id_pc),
        .to_id_inst        (to_id_inst),
        .to_id_excp        (to_id_excp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one fetch slot, whether its data is in hand, and a
    // count of stale returns still owed by memory.
    bit          m_busy, m_got, m_excp;
    logic [31:0] m_pc, m_inst;
    int          m_stale;
    bit          n_busy, n_got, n_excp;
    logic [31:0] n_pc, n_inst;
    int          n_stale;
    bit          e_valid;
    logic [68:0] e_vec;

    function automatic bit mis(input logic [31:0] p);
        return ADEF_ON && (p[1:0] != 2'b00);
    endfunction

    function automatic stim_t mk(bit fv, logic [31:0] fpc, bit fl, bit dok, logic [31:0] rd, bit ida);
        stim_t s;
        s.fv = fv; s.fpc = fpc; s.fl = fl; s.dok = dok; s.rd = rd; s.ida = ida;
        return s;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_got = 0; m_excp = 0; m_pc = 32'h1c00_0000; m_inst = 0; m_stale = 0;
    endtask

    task automatic model_eval(input stim_t s);
        bit fresh, deliver, allow;
        logic [31:0] inst;
        fresh   = s.dok && (m_stale == 0);
        deliver = m_busy && (m_excp || m_got || fresh);
        allow   = !m_busy || (deliver && s.ida);
        inst    = m_excp ? 32'h0 : (m_got ? m_inst : s.rd);
        e_valid = deliver && !s.fl;
        e_vec   = {e_valid, allow, m_busy && m_excp, 2'(m_stale),
                   e_valid ? m_pc : 32'h0, e_valid ? inst : 32'h0};
        n_busy = m_busy; n_got = m_got; n_excp = m_excp; n_pc = m_pc; n_inst = m_inst;
        n_stale = m_stale - ((s.dok && m_stale > 0) ? 1 : 0);
        if (s.fl) begin
            if (m_busy && !m_got && !fresh && !m_excp) n_stale++;
            if (s.fv && allow && !mis(s.fpc)) n_stale++;
            n_busy = 0; n_got = 0;
        end else if (s.fv && allow) begin
            n_busy = 1; n_pc = s.fpc; n_got = 0; n_excp = mis(s.fpc);
        end else if (deliver && s.ida) begin
            n_busy = 0; n_got = 0;
        end else if (fresh && m_busy) begin
            n_got = 1; n_inst = s.rd;
        end
    endtask

    task automatic model_commit();
        m_busy = n_busy; m_got = n_got; m_excp = n_excp; m_pc = n_pc; m_inst = n_inst;
        m_stale = n_stale;
    endtask

    function automatic logic [68:0] obs();
        return {to_id_valid, to_allowin, to_id_excp, dut.cancel_cnt,
                e_valid ? to_id_pc : 32'h0, e_valid ? to_id_inst : 32'h0};
    endfunction

    task automatic drive(input stim_t s);
        @(negedge clk);
        from_valid = s.fv; from_pc = s.fpc; flush = s.fl;
        inst_sram_data_ok = s.dok; inst_sram_rdata = s.rd; id_allowin = s.ida;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        from_valid = 0; from_pc = 0; flush = 0; inst_sram_data_ok = 0;
        inst_sram_rdata = 0; id_allowin = 1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        from_valid = 0; from_pc = 0; flush = 0; inst_sram_data_ok = 0;
        inst_sram_rdata = 0; id_allowin = 1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({to_id_valid, to_allowin, to_id_excp, dut.cancel_cnt} !== 5'b01000) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 01000", {to_id_valid, to_allowin, to_id_excp, dut.cancel_cnt});
        end
        checks++;
        if (to_id_pc !== 32'h1c00_0000) begin
            failures++;
            $display("FAIL reset_pc: got %h expected 1c000000", to_id_pc);
        end
        resetn = 1'b1;
    endtask

    task automatic test_stream();
        stim_t t[$];
        t = '{mk(1, 32'h1c00_0000, 0, 0, 32'h0,         1),
              mk(1, 32'h1c00_0004, 0, 1, 32'h0280_0000, 1),
              mk(0, 32'h0,         0, 1, 32'h0280_0000, 1),
              mk(0, 32'h0,         0, 0, 32'h0,         1)};
        foreach (t[i]) begin
            drive(t[i]); model_eval(t[i]);
            checks++;
            if (obs() !== e_vec) begin
                failures++;
                $display("FAIL stream step %0d: got %h expected %h", i, obs(), e_vec);
            end
            @(posedge clk); model_commit();
        end
    endtask

    task automatic test_stall();
        stim_t t[$];
        t = '{mk(1, 32'h1c00_0010, 0, 0, 32'h0,         0),
              mk(1, 32'h1c00_0014, 0, 1, 32'h0011_2233, 0),
              mk(1, 32'h1c00_0014, 0, 0, 32'h0,         0),
              mk(1, 32'h1c00_0014, 0, 0, 32'h0,         0),
              mk(1, 32'h1c00_0014, 0, 0, 32'h0,         1),
              mk(0, 32'h0,         0, 1, 32'h0044_5566, 1),
              mk(0, 32'h0,         0, 0, 32'h0,         1)};
        foreach (t[i]) begin
            drive(t[i]); model_eval(t[i]);
            checks++;
            if (obs() !== e_vec) begin
                failures++;
                $display("FAIL stall step %0d: got %h expected %h", i, obs(), e_vec);
            end
            @(posedge clk); model_commit();
        end
    endtask

    task automatic test_flush_wait();
        stim_t t[$];
        t = '{mk(1, 32'h1c00_0008, 0, 0, 32'h0,         1),
              mk(0, 32'h0,         1, 0, 32'h0,         1),
              mk(0, 32'h0,         0, 1, 32'hdead_beef, 1),
              mk(1, 32'h1c00_0100, 0, 0, 32'h0,         1),
              mk(0, 32'h0,         0, 1, 32'h1111_1111, 1),
              mk(0, 32'h0,         0, 0, 32'h0,         1)};
        foreach (t[i]) begin
            drive(t[i]); model_eval(t[i]);
            checks++;
            if (obs() !== e_vec) begin
                failures++;
                $display("FAIL flush_wait step %0d: got %h expected %h", i, obs(), e_vec);
            end
            @(posedge clk); model_commit();
        end
    endtask

    task automatic test_double_cancel();
        stim_t t[$];
        t = '{mk(1, 32'h1c00_0200, 0, 0, 32'h0,         1),
              mk(1, 32'h1c00_0204, 1, 0, 32'h0,         1),
              mk(1, 32'h1c00_0208, 1, 0, 32'h0,         1),
              mk(1, 32'h1c00_020c, 0, 0, 32'h0,         1),
              mk(0, 32'h0,         0, 1, 32'hbad0_0001, 1),
              mk(0, 32'h0,         0, 1, 32'hbad0_0002, 1),
              mk(0, 32'h0,         0, 1, 32'h2222_2222, 1),
              mk(0, 32'h0,         0, 0, 32'h0,         1)};
        foreach (t[i]) begin
            drive(t[i]); model_eval(t[i]);
            checks++;
            if (obs() !== e_vec) begin
                failures++;
                $display("FAIL double_cancel step %0d: got %h expected %h", i, obs(), e_vec);
            end
            @(posedge clk); model_commit();
        end
    endtask

    task automatic test_flush_data();
        stim_t t[$];
        t = '{mk(1, 32'h1c00_0300, 0, 0, 32'h0,         1),
              mk(0, 32'h0,         1, 0, 32'h0,         1),
              mk(1, 32'h1c00_0304, 1, 1, 32'h5a5a_0001, 1),
              mk(0, 32'h0,         0, 1, 32'h5a5a_0002, 1),
              mk(1, 32'h1c00_0308, 0, 0, 32'h0,         1),
              mk(0, 32'h0,         0, 1, 32'h3333_3333, 1),
              mk(0, 32'h0,         0, 0, 32'h0,         1)};
        foreach (t[i]) begin
            drive(t[i]); model_eval(t[i]);
            checks++;
            if (obs() !== e_vec) begin
                failures++;
                $display("FAIL flush_data step %0d: got %h expected %h", i, obs(), e_vec);
            end
            @(posedge clk); model_commit();
        end
    endtask

    task automatic test_adef();
        stim_t t[$];
        t = '{mk(1, 32'h1c00_0002, 0, 0, 32'h0, 1),
              mk(0, 32'h0,         0, 0, 32'h0, 1),
              mk(0, 32'h0,         0, 0, 32'h0, 1)};
        foreach (t[i]) begin
            drive(t[i]); model_eval(t[i]);
            checks++;
            if (obs() !== e_vec) begin
                failures++;
                $display("FAIL adef step %0d: got %h expected %h", i, obs(), e_vec);
            end
            @(posedge clk); model_commit();
        end
    endtask

    task automatic test_random();
        stim_t s;
        for (int i = 0; i < 600; i++) begin
            s.ida = ($urandom_range(0, 3) != 0);
            s.fv  = ($urandom_range(0, 2) != 0);
            s.fpc = 32'h1c00_0000 + ($urandom_range(0, 1023) << 2);
            if (ADEF_ON && ($urandom_range(0, 7) == 0)) s.fpc = s.fpc + 32'd2;
            s.rd  = $urandom;
            s.dok = ((m_stale > 0) || (m_busy && !m_got && !m_excp)) && ($urandom_range(0, 1) == 1);
            s.fl  = ($urandom_range(0, 7) == 0);
            if (s.fl) begin
                model_eval(s);
                if (n_stale > 2) s.fl = 0;
            end
            drive(s); model_eval(s);
            checks++;
            if (obs() !== e_vec) begin
                failures++;
                $display("FAIL random cycle %0d: got %h expected %h", i, obs(), e_vec);
            end
            @(posedge clk); model_commit();
        end
    endtask

    task automatic test_async_reset();
        stim_t t[$];
        do_reset();
        t = '{mk(1, 32'h1c00_0400, 0, 0, 32'h0,         0),
              mk(0, 32'h0,         0, 1, 32'h4444_4444, 0),
              mk(0, 32'h0,         0, 0, 32'h0,         0)};
        foreach (t[i]) begin
            drive(t[i]); model_eval(t[i]);
            checks++;
            if (obs() !== e_vec) begin
                failures++;
                $display("FAIL reset_setup step %0d: got %h expected %h", i, obs(), e_vec);
            end
            if (i < 2) begin
                @(posedge clk); model_commit();
            end
        end
        #2 resetn = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({to_id_valid, to_allowin, dut.cancel_cnt} !== 4'b0100) begin
            failures++;
            $display("FAIL async_reset_buffer: got %b expected 0100", {to_id_valid, to_allowin, dut.cancel_cnt});
        end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++;
        if (to_id_pc !== 32'h1c00_0000) begin
            failures++;
            $display("FAIL async_reset_pc: got %h expected 1c000000", to_id_pc);
        end
        t = '{mk(1, 32'h1c00_0500, 0, 0, 32'h0, 1),
              mk(0, 32'h0,         1, 0, 32'h0, 1)};
        foreach (t[i]) begin
            drive(t[i]); model_eval(t[i]);
            checks++;
            if (obs() !== e_vec) begin
                failures++;
                $display("FAIL reset_cancel_setup step %0d: got %h expected %h", i, obs(), e_vec);
            end
            @(posedge clk); model_commit();
        end
        #2 resetn = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut.cancel_cnt !== 2'd0) begin
            failures++;
            $display("FAIL async_reset_cancel: got %0d expected 0", dut.cancel_cnt);
        end
        @(negedge clk);
        resetn = 1'b1;
        t = '{mk(1, 32'h1c00_0600, 0, 0, 32'h0,         1),
              mk(0, 32'h0,         0, 1, 32'h6666_6666, 1)};
        foreach (t[i]) begin
            drive(t[i]); model_eval(t[i]);
            checks++;
            if (obs() !== e_vec) begin
                failures++;
                $display("FAIL after_reset step %0d: got %h expected %h", i, obs(), e_vec);
            end
            @(posedge clk); model_commit();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush_wait();
        test_double_cancel();
        test_flush_data();
        if (ADEF_ON) test_adef();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
